// File: rtl/if_stage_bpu_pkg.sv
// if_stage_bpu_pkg: shared defaults, counter encodings and helpers for the fetch stage.
package if_stage_bpu_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;
    localparam int BTB_ENTRIES_DEF = 16;
    localparam int IF_IPD_BUS_W = 1 + 32 + 1 + 32;

    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        return taken ? (c == ST ? ST : ctr_t'(c + 2'd1)) : (c == SNT ? SNT : ctr_t'(c - 2'd1));
    endfunction
endpackage

// File: rtl/if_stage_bpu_btb.sv
// if_btb: direct-mapped BTB with 2-bit counters; one combinational lookup port, one training port.
module if_btb
    import if_stage_bpu_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES_DEF,
    parameter int IDX_W = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag    [ENTRIES];
    logic [31:0]        target [ENTRIES];
    ctr_t               ctr    [ENTRIES];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, u_hit;
    logic             unused_lsb;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[31:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];
    assign unused_lsb = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign l_hit = valid[l_idx] && tag[l_idx] == l_tag;
    assign u_hit = valid[u_idx] && tag[u_idx] == u_tag;
    assign pred_taken = l_hit && ctr[l_idx][1];
    assign pred_target = target[l_idx];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= WNT;
        end else if (upd_valid) begin
            if (u_hit) begin
                ctr[u_idx] <= ctr_next(ctr[u_idx], upd_taken);
            end else if (upd_taken) begin
                valid[u_idx] <= 1'b1;
                ctr[u_idx] <= WT;
            end
        end
    end

    // On a hit the tag rewrite is a no-op, so taken training always writes tag and target.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag[u_idx] <= u_tag;
            target[u_idx] <= upd_target;
        end
    end
endmodule

// File: rtl/if_stage_bpu.sv
// if_stage_bpu: fetch stage driving the inst RAM and handing PC plus prediction to IPD.
// Define IF_BPRED_EN to build the BTB predictor; otherwise fetch is static not-taken.
module if_stage_bpu
    import if_stage_bpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEF,
    localparam int IDX_W = $clog2(BTB_ENTRIES)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_allow_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        if_to_ipd_valid,
    output logic [31:0] if_to_ipd_pc,
    output logic        if_to_ipd_pred_taken,
    output logic [31:0] if_to_ipd_pred_target,
    output logic        inst_ram_en,
    output logic [31:0] inst_ram_addr,
    output logic [3:0]  inst_ram_w_en,
    output logic [31:0] inst_ram_w_data
);
    logic [31:0] pc, seq_pc, pred_nextpc, next_pc;
    logic        if_valid, pred_taken, if_allow_in, advance;
    logic [IF_IPD_BUS_W-1:0] ipd_bus;

    assign seq_pc = pc + 32'd4;

`ifdef IF_BPRED_EN
    logic [31:0] btb_target;

    if_btb #(.ENTRIES(BTB_ENTRIES), .IDX_W(IDX_W)) u_btb (
        .clk        (clk),
        .resetn     (resetn),
        .lookup_pc  (pc),
        .pred_taken (pred_taken),
        .pred_target(btb_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    assign pred_nextpc = pred_taken ? btb_target : seq_pc;
`else
    logic unused_upd;

    assign pred_taken = 1'b0;
    assign pred_nextpc = seq_pc;
    assign unused_upd = ^{upd_valid, upd_pc, upd_taken, upd_target, IDX_W[0]};
`endif

    assign if_allow_in = ~if_valid | id_allow_in;
    assign advance = redirect_valid | if_allow_in;
    assign next_pc = redirect_valid ? redirect_pc : pred_nextpc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc <= RESET_PC - 32'd4;
            if_valid <= 1'b0;
        end else if (advance) begin
            pc <= next_pc;
            if_valid <= 1'b1;
        end
    end

    // A redirect squashes the instruction sitting in IF before IPD can take it.
    assign ipd_bus = {if_valid & ~redirect_valid, pc, pred_taken, pred_nextpc};
    assign {if_to_ipd_valid, if_to_ipd_pc, if_to_ipd_pred_taken, if_to_ipd_pred_target} = ipd_bus;

    assign inst_ram_en = advance;
    assign inst_ram_addr = next_pc;
    assign inst_ram_w_en = 4'd0;
    assign inst_ram_w_data = 32'd0;
endmodule

// File: doc/if_stage_bpu.md
# if_stage_bpu

Parametrised instruction-fetch stage, the first pipeline stage, feeding IPD. It maintains the fetch PC, drives the synchronous inst RAM and hands PC plus prediction info to IPD under the valid/allow_in handshake. It adds a direct-mapped BTB with 2-bit saturating counters for dynamic next-PC prediction, trained and redirected from ID.

## Interface
Parameters:
- RESET_PC, 32'h1c000000, address of the first fetched instruction.
- BTB_ENTRIES, 16, BTB depth; power of 2, 2..256.
- IDX_W, $clog2(BTB_ENTRIES), index width (derived, not overridden).

Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state on its rising edge.
- resetn, in, 1, asynchronous, active-low reset.
- id_allow_in, in, 1, ID accepts an instruction this cycle.
- redirect_valid, in, 1, ID detected a mispredict; flush and refetch.
- redirect_pc, in, 32, correct next PC.
- upd_valid, in, 1, resolved branch training strobe.
- upd_pc, in, 32, PC of the resolved branch.
- upd_taken, in, 1, branch actually taken.
- upd_target, in, 32, actual taken target.
- if_to_ipd_valid, out, 1, IF holds a valid instruction.
- if_to_ipd_pc, out, 32, PC of that instruction.
- if_to_ipd_pred_taken, out, 1, IF predicted taken.
- if_to_ipd_pred_target, out, 32, predicted next PC (taken target or pc+4).
- inst_ram_en, out, 1, RAM read enable.
- inst_ram_addr, out, 32, RAM read address.
- inst_ram_w_en, out, 4, constant 0.
- inst_ram_w_data, out, 32, constant 0.

## Operation
- Registers: pc, if_valid, pred_taken, pred_target; BTB arrays valid[], tag[], target[], ctr[2].
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Hit = valid[idx] && tag match.
- Prediction: pred_taken = hit && ctr[idx][1]; pred_nextpc = pred_taken ? target[idx] : pc+4 (32-bit wrap).
- if_allow_in = ~if_valid | id_allow_in. advance = redirect_valid | if_allow_in.
- next_pc = redirect_valid ? redirect_pc : pred_nextpc. Redirect has priority over prediction and stall.
- inst_ram_en = advance; inst_ram_addr = next_pc. When en=0 RAM output holds, so a stalled instruction is preserved.
- On advance: pc <= next_pc, if_valid <= 1, pred regs <= prediction computed for next_pc's fetch (looked up when next_pc becomes pc; outputs are combinational from pc).
- Redirect squashes the instruction currently in IF (ID guarantees it is younger); it is never presented.
- Training on upd_valid at index of upd_pc: hit → ctr saturating ++ if taken, -- if not (00..11), target <= upd_target if taken. Miss and taken → allocate: valid=1, tag, target, ctr=2'b10. Miss and not taken → no change.
- Lookup and update of the same index in one cycle: lookup sees pre-edge contents.

## Timing
- Reset (async assert): pc = RESET_PC-4, if_valid = 0, all BTB valid = 0, ctr = 2'b01; outputs: if_to_ipd_valid 0, pred_taken 0, inst_ram_en 1 once released.
- First cycle after release: next_pc = RESET_PC (BTB empty); next edge if_valid=1, pc=RESET_PC.
- Fetch latency: address driven cycle N, instruction with its PC valid in IF cycle N+1.
- Throughput 1 instr/cycle with id_allow_in held high; taken prediction costs zero bubbles.
- Redirect: redirect_valid in cycle N → cycle N+1 if_to_ipd_pc = redirect_pc, valid 1. One-cycle bubble is ID's responsibility.
- Training visible to lookups from the cycle after upd_valid.
- Reset mid-operation: everything returns to reset values immediately; BTB contents lost.

## Configuration
- IF_BPRED_EN defined: BTB and counters built, behaviour as above.
- Undefined: no BTB storage; pred_taken tied 0, pred_target = pc+4, upd_* ignored; static not-taken fetch, redirect unchanged.

## Structure
- Shared package: RESET_PC default, counter encodings (SNT 00, WNT 01, WT 10, ST 11), BTB_ENTRIES default, IF→IPD bus width.
- One sub-module: if_btb (arrays, lookup port, update port, reset); instantiated only under IF_BPRED_EN.

## Test plan
- Reset release, id_allow_in=1 → RAM addresses 1c000000, 1c000004, 1c000008; IPD PCs lag one cycle, valid from 2nd cycle.
- id_allow_in low 3 cycles at pc=1c000008 → inst_ram_en 0, pc/valid held, resumes at 1c00000c.
- upd taken pc=1c000010→1c000100, then refetch 1c000010 → pred_taken 1, next address 1c000100.
- Two not-taken updates on that entry → ctr 10→01→00; next fetch pred_taken 0, next address 1c000014.
- redirect_valid with id_allow_in=0, redirect_pc=1c000200 → next cycle pc=1c000200, valid 1; squashed instruction never presented.
- Aliasing: upd at 1c000010 then 1c000050 (BTB_ENTRIES=16) → tag replaced; 1c000010 misses.
